fetch_sequencer: RTL and testbench

//  Controls the IF stage. Each cycle it drives the program counter's write-enable and next-PC value.
//  It also arbitrates the instruction memory write port between the boot-time program loader and normal fetch.

---
 rtl/fetch_sequencer_pkg.sv | 13 +
 rtl/fetch_sequencer_if.sv | 39 +++
 rtl/fetch_perf_counter.sv | 38 +++
 rtl/fetch_sequencer.sv | 105 ++++++++++
 tb/tb_fetch_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the IF-stage fetch sequencer: run-state encodings and parameter defaults.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        FS_LOAD = 2'b00,
        FS_RUN  = 2'b01,
        FS_HALT = 2'b10
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam int          IMEM_DEPTH_DEF = 256;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundles the fetch sequencer's control, loader and PC/IMEM signals; slave = sequencer side.
interface fetch_sequencer_if #(
    parameter int AW = 8
);
    logic          start_i;
    logic          stall_i;
    logic          branch_taken_i;
    logic [31:0]   branch_target_i;
    logic          jump_i;
    logic [31:0]   jump_target_i;
    logic          halt_i;
    logic [31:0]   pc_plus_i;
    logic          load_req_i;
    logic [AW-1:0] load_addr_i;
    logic [31:0]   load_data_i;
    logic          load_gnt_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_waddr_o;
    logic [31:0]   imem_wdata_o;
    logic          pc_write_o;
    logic [31:0]   pc_next_o;
    logic          flush_o;
    logic [1:0]    state_o;

    modport master (
        output start_i, stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
               halt_i, pc_plus_i, load_req_i, load_addr_i, load_data_i,
        input  load_gnt_o, imem_we_o, imem_waddr_o, imem_wdata_o, pc_write_o, pc_next_o,
               flush_o, state_o
    );

    modport slave (
        input  start_i, stall_i, branch_taken_i, branch_target_i, jump_i, jump_target_i,
               halt_i, pc_plus_i, load_req_i, load_addr_i, load_data_i,
        output load_gnt_o, imem_we_o, imem_waddr_o, imem_wdata_o, pc_write_o, pc_next_o,
               flush_o, state_o
    );

endinterface

// File: rtl/fetch_perf_counter.sv
// Fetch/stall cycle counters for the fetch sequencer; only present when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_i,
    input  logic        pc_write_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (run_i) begin
            if (pc_write_i) fetch_cnt_d = fetch_cnt_q + 32'd1;
            else            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: LOAD/RUN/HALT run-state, next-PC muxing and IMEM loader arbitration.
// Optional FETCH_PERF_CNT_EN adds fetch/stall cycle counter outputs.
//   state   | meaning
//   FS_LOAD | PC held at RESET_PC, loader owns the IMEM write port
//   FS_RUN  | normal fetch: jump > branch > stall > sequential
//   FS_HALT | PC frozen until start_i
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int          AW         = $clog2(IMEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_sequencer_if.slave bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_cnt_o,
    output logic [31:0]      stall_cnt_o
`endif
);

    // One extra bit so the counter can hold IMEM_DEPTH itself.
    localparam int CW = $clog2(IMEM_DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_q, flush_d;
    logic          gnt;
    logic          full;
    logic          redirect;
    logic          pc_write;
    logic [31:0]   pc_next;

    assign full     = (cnt_q == CW'(IMEM_DEPTH));
    assign redirect = bus.jump_i | bus.branch_taken_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flush_d  = 1'b0;
        gnt      = 1'b0;
        pc_write = 1'b1;
        pc_next  = RESET_PC;
        case (state_q)
            FS_LOAD: begin
                gnt   = bus.load_req_i & ~full;
                cnt_d = cnt_q + CW'(gnt);
                if (bus.start_i || full) state_d = FS_RUN;
            end
            FS_RUN: begin
                pc_next = bus.jump_i         ? bus.jump_target_i   :
                          bus.branch_taken_i ? bus.branch_target_i : bus.pc_plus_i;
                if (redirect) begin
                    flush_d = 1'b1;
                end else if (bus.halt_i) begin
                    pc_write = 1'b0;
                    state_d  = FS_HALT;
                end else if (bus.stall_i) begin
                    pc_write = 1'b0;
                end
            end
            FS_HALT: begin
                pc_write = 1'b0;
                pc_next  = bus.pc_plus_i;
                if (bus.start_i) state_d = FS_RUN;
            end
            default: state_d = FS_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_LOAD;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
        end
    end

    assign bus.load_gnt_o   = gnt;
    assign bus.imem_we_o    = gnt;
    assign bus.imem_waddr_o = bus.load_addr_i;
    assign bus.imem_wdata_o = bus.load_data_i;
    assign bus.pc_write_o   = pc_write;
    assign bus.pc_next_o    = pc_next;
    assign bus.flush_o      = flush_q;
    assign bus.state_o      = state_q;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counter u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_i       (state_q == FS_RUN),
        .pc_write_i  (pc_write),
        .fetch_cnt_o (fetch_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized run against a reference model.
module tb_fetch_sequencer;

    localparam int          DEPTH = 256;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    fetch_sequencer_if #(.AW(8)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    fetch_sequencer #(.RESET_PC(RPC), .IMEM_DEPTH(DEPTH), .AW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o (fetch_cnt),
        .stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: run state 0=LOAD 1=RUN 2=HALT, loader words accepted, pending flush.
    int          m_state;
    int          m_cnt;
    logic        m_flush;
    logic        e_gnt;
    logic        e_pcw;
    logic [31:0] e_pcn;

    function automatic void model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_flush = 1'b0;
    endfunction

    function automatic void calc();
        e_gnt = 1'b0;
        e_pcw = 1'b0;
        e_pcn = RPC;
        if (m_state == 0) begin
            e_pcw = 1'b1;
            e_gnt = bus.load_req_i && (m_cnt < DEPTH);
        end else if (m_state == 1) begin
            if (bus.jump_i)              e_pcn = bus.jump_target_i;
            else if (bus.branch_taken_i) e_pcn = bus.branch_target_i;
            else                         e_pcn = bus.pc_plus_i;
            e_pcw = bus.jump_i || bus.branch_taken_i || !(bus.stall_i || bus.halt_i);
        end
    endfunction

    task automatic tick();
        bit redir;
        calc();
        redir = bus.jump_i || bus.branch_taken_i;
        @(posedge clk);
        case (m_state)
            0: begin
                m_flush = 1'b0;
                if (bus.start_i || m_cnt == DEPTH) m_state = 1;
                if (e_gnt) m_cnt++;
            end
            1: begin
                m_flush = redir;
                if (!redir && bus.halt_i) m_state = 2;
            end
            default: begin
                m_flush = 1'b0;
                if (bus.start_i) m_state = 1;
            end
        endcase
        @(negedge clk);
    endtask

    task automatic idle();
        bus.start_i = 0; bus.stall_i = 0; bus.branch_taken_i = 0; bus.branch_target_i = 0;
        bus.jump_i = 0; bus.jump_target_i = 0; bus.halt_i = 0; bus.pc_plus_i = 0;
        bus.load_req_i = 0; bus.load_addr_i = 0; bus.load_data_i = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #3;
        checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", bus.state_o); end
        checks++; if (bus.pc_write_o !== 1'b1) begin errors++; $display("FAIL reset_pcw got %b want 1", bus.pc_write_o); end
        checks++; if (bus.pc_next_o !== RPC) begin errors++; $display("FAIL reset_pcn got %h want %h", bus.pc_next_o, RPC); end
        checks++; if (bus.load_gnt_o !== 1'b0 || bus.imem_we_o !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b/%b want 0/0", bus.load_gnt_o, bus.imem_we_o); end
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", bus.flush_o); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        logic [31:0] data [3];
        data[0] = 32'hAAAA_AAAA; data[1] = 32'hBBBB_BBBB; data[2] = 32'hCCCC_CCCC;
        for (int i = 0; i < 3; i++) begin
            bus.load_req_i = 1; bus.load_addr_i = 8'(i); bus.load_data_i = data[i];
            #1;
            checks++; if (bus.load_gnt_o !== 1'b1 || bus.imem_we_o !== 1'b1) begin errors++; $display("FAIL load_gnt[%0d] got %b/%b want 1/1", i, bus.load_gnt_o, bus.imem_we_o); end
            checks++; if (bus.imem_waddr_o !== 8'(i) || bus.imem_wdata_o !== data[i]) begin errors++; $display("FAIL load_pass[%0d] got %h/%h want %h/%h", i, bus.imem_waddr_o, bus.imem_wdata_o, i, data[i]); end
            checks++; if (bus.pc_write_o !== 1'b1 || bus.pc_next_o !== RPC) begin errors++; $display("FAIL load_pc[%0d] got %b/%h want 1/%h", i, bus.pc_write_o, bus.pc_next_o, RPC); end
            tick();
        end
        idle();
        bus.start_i = 1;
        #1;
        checks++; if (bus.state_o !== 2'b00) begin errors++; $display("FAIL load_hold_state got %b want 00", bus.state_o); end
        tick();
        bus.start_i = 0;
        #1;
        checks++; if (bus.state_o !== 2'b01) begin errors++; $display("FAIL start_run got %b want 01", bus.state_o); end
    endtask

    task automatic test_run_seq();
        idle(); bus.pc_plus_i = 32'h4;
        #1;
        checks++; if (bus.pc_next_o !== 32'h4 || bus.pc_write_o !== 1'b1) begin errors++; $display("FAIL run_seq got %h/%b want 4/1", bus.pc_next_o, bus.pc_write_o); end
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL run_seq_flush got %b want 0", bus.flush_o); end
        bus.load_req_i = 1;
        #1;
        checks++; if (bus.load_gnt_o !== 1'b0 || bus.imem_we_o !== 1'b0) begin errors++; $display("FAIL run_load_ignored got %b/%b want 0/0", bus.load_gnt_o, bus.imem_we_o); end
        tick();
    endtask

    task automatic test_branch_stall();
        idle(); bus.pc_plus_i = 32'h8; bus.stall_i = 1; bus.branch_taken_i = 1; bus.branch_target_i = 32'h40;
        #1;
        checks++; if (bus.pc_next_o !== 32'h40 || bus.pc_write_o !== 1'b1) begin errors++; $display("FAIL branch_over_stall got %h/%b want 40/1", bus.pc_next_o, bus.pc_write_o); end
        tick();
        idle(); bus.pc_plus_i = 32'h44;
        #1;
        checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL branch_flush got %b want 1", bus.flush_o); end
        tick();
        #1;
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL branch_flush_end got %b want 0", bus.flush_o); end
        bus.stall_i = 1;
        #1;
        checks++; if (bus.pc_write_o !== 1'b0) begin errors++; $display("FAIL stall_hold got %b want 0", bus.pc_write_o); end
        tick();
    endtask

    task automatic test_jump_priority();
        idle(); bus.jump_i = 1; bus.jump_target_i = 32'h80; bus.branch_taken_i = 1; bus.branch_target_i = 32'h40; bus.halt_i = 1;
        #1;
        checks++; if (bus.pc_next_o !== 32'h80 || bus.pc_write_o !== 1'b1) begin errors++; $display("FAIL jump_priority got %h/%b want 80/1", bus.pc_next_o, bus.pc_write_o); end
        tick();
        idle();
        #1;
        checks++; if (bus.state_o !== 2'b01 || bus.flush_o !== 1'b1) begin errors++; $display("FAIL jump_drops_halt got %b/%b want 01/1", bus.state_o, bus.flush_o); end
        tick();
    endtask

    task automatic test_halt();
        idle(); bus.halt_i = 1; bus.pc_plus_i = 32'h90;
        #1;
        checks++; if (bus.pc_write_o !== 1'b0) begin errors++; $display("FAIL halt_pcw got %b want 0", bus.pc_write_o); end
        tick();
        idle(); bus.load_req_i = 1; bus.stall_i = 1; bus.halt_i = 1;
        #1;
        checks++; if (bus.state_o !== 2'b10) begin errors++; $display("FAIL halt_state got %b want 10", bus.state_o); end
        checks++; if (bus.load_gnt_o !== 1'b0 || bus.pc_write_o !== 1'b0 || bus.flush_o !== 1'b0) begin errors++; $display("FAIL halt_outputs got %b/%b/%b want 0/0/0", bus.load_gnt_o, bus.pc_write_o, bus.flush_o); end
        tick();
        idle(); bus.start_i = 1;
        tick();
        bus.start_i = 0;
        #1;
        checks++; if (bus.state_o !== 2'b01) begin errors++; $display("FAIL halt_resume got %b want 01", bus.state_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            bus.start_i         = ($urandom_range(7) == 0);
            bus.stall_i         = ($urandom_range(3) == 0);
            bus.branch_taken_i  = ($urandom_range(4) == 0);
            bus.branch_target_i = $urandom;
            bus.jump_i          = ($urandom_range(6) == 0);
            bus.jump_target_i   = $urandom;
            bus.halt_i          = ($urandom_range(9) == 0);
            bus.pc_plus_i       = $urandom;
            bus.load_req_i      = $urandom_range(1);
            #1;
            calc();
            checks++; if (bus.state_o !== 2'(m_state) || bus.flush_o !== m_flush) begin errors++; $display("FAIL rand_state[%0d] got %b/%b want %0d/%b", n, bus.state_o, bus.flush_o, m_state, m_flush); end
            checks++; if (bus.load_gnt_o !== e_gnt || bus.imem_we_o !== e_gnt) begin errors++; $display("FAIL rand_gnt[%0d] got %b/%b want %b", n, bus.load_gnt_o, bus.imem_we_o, e_gnt); end
            checks++; if (bus.pc_write_o !== e_pcw || (e_pcw && bus.pc_next_o !== e_pcn)) begin errors++; $display("FAIL rand_pc[%0d] got %b/%h want %b/%h", n, bus.pc_write_o, bus.pc_next_o, e_pcw, e_pcn); end
            tick();
        end
    endtask

    task automatic test_auto_run();
        int gnt_bad;
        test_reset();
        gnt_bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.load_req_i = 1; bus.load_addr_i = 8'(i); bus.load_data_i = $urandom;
            #1;
            if (bus.load_gnt_o !== 1'b1) gnt_bad++;
            tick();
        end
        checks++; if (gnt_bad != 0) begin errors++; $display("FAIL fill_gnt got %0d refused want 0", gnt_bad); end
        #1;
        checks++; if (bus.state_o !== 2'b00 || bus.load_gnt_o !== 1'b0 || bus.imem_we_o !== 1'b0) begin errors++; $display("FAIL full_refuse got %b/%b/%b want 00/0/0", bus.state_o, bus.load_gnt_o, bus.imem_we_o); end
        tick();
        idle(); bus.pc_plus_i = 32'h1234; bus.branch_taken_i = 1; bus.branch_target_i = 32'h200;
        #1;
        checks++; if (bus.state_o !== 2'b01) begin errors++; $display("FAIL auto_run got %b want 01", bus.state_o); end
        tick();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.state_o !== 2'b00 || bus.pc_next_o !== RPC || bus.pc_write_o !== 1'b1 || bus.flush_o !== 1'b0) begin errors++; $display("FAIL mid_reset got %b/%h/%b/%b want 00/%h/1/0", bus.state_o, bus.pc_next_o, bus.pc_write_o, bus.flush_o, RPC); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(); bus.load_req_i = 1;
        #1;
        checks++; if (bus.load_gnt_o !== 1'b1) begin errors++; $display("FAIL counter_cleared got %b want 1", bus.load_gnt_o); end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_load();
        test_run_seq();
        test_branch_stall();
        test_jump_priority();
        test_halt();
        test_random();
        test_auto_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
